// File: rtl/plot_cmd_queue.sv
// Command queue in front of game_plot: buffers cell-draw commands and issues them
// one at a time, with a board-clear sweep that repaints all 256 cells.
module plot_cmd_queue #(
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic [3:0]    cmd_x,
  input  logic [3:0]    cmd_y,
  input  logic [2:0]    cmd_colour,
  output logic          cmd_ready,
  input  logic          clear_req,
  input  logic [2:0]    clear_colour,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          game_plot,
  output logic [3:0]    game_x,
  output logic [3:0]    game_y,
  output logic [2:0]    game_colour,
  input  logic          waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_GAP,
    S_SWEEP_ISSUE
  } state_t;

  state_t        state_q, state_d;
  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          sweep_q, sweep_d;
  logic          started_q, started_d;
  logic [7:0]    cell_q, cell_d;
  logic [2:0]    clr_colour_q;
  logic [3:0]    gx_q, gy_q;
  logic [2:0]    gc_q;

  logic          clear_acc;
  logic          sweep_go;
  logic          push;
  logic          pop;
  logic          load_cell;
  logic [2:0]    sweep_colour;

  // sweep_q covers both a pending clear and a running sweep; it blocks new pushes.
  assign cmd_ready    = !rst && (count_q < CW'(DEPTH)) && !sweep_q;
  assign clear_acc    = clear_req && !sweep_q;
  assign sweep_go     = sweep_q || clear_acc;
  assign push         = cmd_valid && cmd_ready && !clear_req;
  assign sweep_colour = clear_acc ? clear_colour : clr_colour_q;

  assign busy        = (state_q != S_IDLE) || (count_q != '0) || sweep_q;
  assign count       = count_q;
  assign game_plot   = (state_q == S_ISSUE) || (state_q == S_SWEEP_ISSUE);
  assign game_x      = gx_q;
  assign game_y      = gy_q;
  assign game_colour = gc_q;

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    started_d = started_q;
    cell_d    = cell_q;
    pop       = 1'b0;
    load_cell = 1'b0;
    if (clear_acc) begin
      sweep_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (sweep_go) begin
          cell_d    = 8'd0;
          started_d = 1'b1;
          load_cell = 1'b1;
          state_d   = S_SWEEP_ISSUE;
        end else if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE, S_SWEEP_ISSUE: begin
        if (waitrequest) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!waitrequest) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
        if (sweep_go) begin
          if (!started_q) begin
            // Clear arrived while a queued cell was in flight: start the sweep now.
            cell_d    = 8'd0;
            started_d = 1'b1;
            load_cell = 1'b1;
            state_d   = S_SWEEP_ISSUE;
          end else if (cell_q == 8'hFF) begin
            sweep_d   = 1'b0;
            started_d = 1'b0;
          end else begin
            cell_d    = cell_q + 8'd1;
            load_cell = 1'b1;
            state_d   = S_SWEEP_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sweep_q      <= 1'b0;
      started_q    <= 1'b0;
      cell_q       <= 8'd0;
      clr_colour_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      started_q <= started_d;
      cell_q    <= cell_d;
      if (clear_acc) begin
        clr_colour_q <= clear_colour;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_y, cmd_x, cmd_colour};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_acc) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Output registers double as the registered read port of the command buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      gx_q <= 4'd0;
      gy_q <= 4'd0;
      gc_q <= 3'd0;
    end else if (pop) begin
      gy_q <= mem_q[rd_ptr_q][10:7];
      gx_q <= mem_q[rd_ptr_q][6:3];
      gc_q <= mem_q[rd_ptr_q][2:0];
    end else if (load_cell) begin
      gx_q <= cell_d[3:0];
      gy_q <= cell_d[7:4];
      gc_q <= sweep_colour;
    end
  end

endmodule

// File: tb/tb_plot_cmd_queue.sv
// Directed bench for plot_cmd_queue with a simple game_plot model that holds
// waitrequest for WAIT_CYC cycles after each accepted cell.
module tb_plot_cmd_queue;
  localparam int DEPTH    = 8;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int WAIT_CYC = 34;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [3:0]    cmd_x = 4'd0;
  logic [3:0]    cmd_y = 4'd0;
  logic [2:0]    cmd_colour = 3'd0;
  logic          cmd_ready;
  logic          clear_req = 1'b0;
  logic [2:0]    clear_colour = 3'd0;
  logic          busy;
  logic [CW-1:0] count;
  logic          game_plot;
  logic [3:0]    game_x;
  logic [3:0]    game_y;
  logic [2:0]    game_colour;
  logic          waitrequest;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int wr_cnt = 0;
  logic [10:0] acc_q[$];
  int          acc_t[$];

  plot_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_colour(cmd_colour),
    .cmd_ready(cmd_ready),
    .clear_req(clear_req), .clear_colour(clear_colour),
    .busy(busy), .count(count),
    .game_plot(game_plot), .game_x(game_x), .game_y(game_y), .game_colour(game_colour),
    .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  assign waitrequest = (wr_cnt != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_cnt != 0) begin
      wr_cnt <= wr_cnt - 1;
    end else if (game_plot === 1'b1) begin
      wr_cnt <= WAIT_CYC;
      acc_q.push_back({game_y, game_x, game_colour});
      acc_t.push_back(cyc);
      $display("cell x=%0d y=%0d colour=%b cyc=%0d", game_x, game_y, game_colour, cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (game_plot !== 1'b0) $display("FAIL reset_plot: got %b want 0", game_plot); else passes++;
    checks++; if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", cmd_ready); else passes++;
    checks++; if ({game_x, game_y, game_colour} !== 11'd0)
      $display("FAIL reset_outs: got %h want 0", {game_x, game_y, game_colour}); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready_release: got %b want 1", cmd_ready); else passes++;
  endtask

  task automatic test_single();
    int n;
    acc_q.delete(); acc_t.delete();
    cmd_valid = 1'b1; cmd_x = 4'd5; cmd_y = 4'd8; cmd_colour = 3'b001;
    tick();
    cmd_valid = 1'b0;
    checks++; if (count !== 4'd1) $display("FAIL single_count: got %0d want 1", count); else passes++;
    tick();
    checks++; if (game_plot !== 1'b1) $display("FAIL single_plot: got %b want 1", game_plot); else passes++;
    checks++; if ({game_x, game_y, game_colour} !== {4'd5, 4'd8, 3'b001})
      $display("FAIL single_cell: got x=%0d y=%0d c=%b want x=5 y=8 c=001", game_x, game_y, game_colour); else passes++;
    wait_idle(200, n);
    checks++; if ((n + 1) !== 38) $display("FAIL single_busy_len: got %0d want 38", n + 1); else passes++;
    checks++; if (acc_q.size() !== 1) $display("FAIL single_accepts: got %0d want 1", acc_q.size()); else passes++;
  endtask

  task automatic test_burst();
    int n;
    int bad_order;
    int bad_space;
    logic [10:0] exp_cell;
    acc_q.delete(); acc_t.delete();
    cmd_valid = 1'b1; cmd_x = 4'd15; cmd_y = 4'd3; cmd_colour = 3'b010;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1; cmd_x = 4'(i); cmd_y = 4'd3; cmd_colour = 3'b010;
      tick();
    end
    checks++; if (count !== 4'd8) $display("FAIL burst_full_count: got %0d want 8", count); else passes++;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL burst_full_ready: got %b want 0", cmd_ready); else passes++;
    cmd_x = 4'd8;
    tick();
    tick();
    cmd_valid = 1'b0;
    checks++; if (count !== 4'd8) $display("FAIL burst_ninth_refused: got %0d want 8", count); else passes++;
    wait_idle(2000, n);
    checks++; if (busy !== 1'b0) $display("FAIL burst_timeout: busy=%b after %0d cycles", busy, n); else passes++;
    checks++; if (acc_q.size() !== 9) $display("FAIL burst_accepts: got %0d want 9", acc_q.size()); else passes++;
    bad_order = 0;
    bad_space = 0;
    for (int i = 1; i < 9 && i < acc_q.size(); i++) begin
      exp_cell = {4'd3, 4'(i - 1), 3'b010};
      if (acc_q[i] !== exp_cell) bad_order++;
      if (acc_t[i] - acc_t[i-1] != 38) bad_space++;
    end
    checks++; if (bad_order !== 0) $display("FAIL burst_order: got %0d bad cells want 0", bad_order); else passes++;
    checks++; if (bad_space !== 0) $display("FAIL burst_spacing: got %0d bad gaps want 0", bad_space); else passes++;
  endtask

  task automatic test_clear();
    int n;
    int ready_bad;
    int bad;
    logic [10:0] exp_cell;
    acc_q.delete(); acc_t.delete();
    for (int i = 1; i <= 3; i++) begin
      cmd_valid = 1'b1; cmd_x = 4'(i); cmd_y = 4'd0; cmd_colour = 3'b010;
      tick();
    end
    cmd_valid = 1'b0;
    checks++; if (count !== 4'd2) $display("FAIL clear_prefill: got %0d want 2", count); else passes++;
    repeat (3) tick();
    clear_colour = 3'b111; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    checks++; if (count !== '0) $display("FAIL clear_flush: got %0d want 0", count); else passes++;
    ready_bad = 0;
    n = 0;
    while (busy && n < 20000) begin
      if (cmd_ready !== 1'b0) ready_bad++;
      tick();
      n++;
    end
    checks++; if (busy !== 1'b0) $display("FAIL clear_timeout: busy=%b after %0d cycles", busy, n); else passes++;
    checks++; if (ready_bad !== 0) $display("FAIL clear_ready_in_sweep: got %0d cycles want 0", ready_bad); else passes++;
    checks++; if (acc_q.size() !== 257) $display("FAIL clear_accepts: got %0d want 257", acc_q.size()); else passes++;
    checks++; if (acc_q.size() == 0 || acc_q[0] !== {4'd0, 4'd1, 3'b010})
      $display("FAIL clear_inflight_cell: got %h want %h", (acc_q.size() > 0) ? acc_q[0] : 11'h7FF, {4'd0, 4'd1, 3'b010}); else passes++;
    bad = 0;
    for (int k = 0; k < 256 && (k + 1) < acc_q.size(); k++) begin
      exp_cell = {8'(k), 3'b111};
      if (acc_q[k+1] !== exp_cell) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL clear_sweep_cells: got %0d bad cells want 0", bad); else passes++;
  endtask

  task automatic test_collision();
    int n;
    acc_q.delete(); acc_t.delete();
    cmd_valid = 1'b1; cmd_x = 4'd9; cmd_y = 4'd9; cmd_colour = 3'b001;
    clear_req = 1'b1; clear_colour = 3'b100;
    tick();
    cmd_valid = 1'b0; clear_req = 1'b0;
    checks++; if (count !== '0) $display("FAIL collide_count: got %0d want 0", count); else passes++;
    checks++; if (game_plot !== 1'b1) $display("FAIL collide_plot: got %b want 1", game_plot); else passes++;
    checks++; if ({game_x, game_y, game_colour} !== {4'd0, 4'd0, 3'b100})
      $display("FAIL collide_first_cell: got x=%0d y=%0d c=%b want x=0 y=0 c=100", game_x, game_y, game_colour); else passes++;
    wait_idle(20000, n);
    checks++; if (busy !== 1'b0) $display("FAIL collide_timeout: busy=%b after %0d cycles", busy, n); else passes++;
    checks++; if (acc_q.size() !== 256) $display("FAIL collide_accepts: got %0d want 256", acc_q.size()); else passes++;
    checks++; if (acc_q.size() == 0 || acc_q[acc_q.size()-1] !== {8'hFF, 3'b100})
      $display("FAIL collide_last_cell: got %h want %h", (acc_q.size() > 0) ? acc_q[acc_q.size()-1] : 11'h0, {8'hFF, 3'b100}); else passes++;
  endtask

  task automatic test_midop_reset();
    int n;
    acc_q.delete(); acc_t.delete();
    cmd_valid = 1'b1; cmd_x = 4'd2; cmd_y = 4'd2; cmd_colour = 3'b011;
    tick();
    cmd_x = 4'd4; cmd_y = 4'd4;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    checks++; if (count !== 4'd1) $display("FAIL midop_precount: got %0d want 1", count); else passes++;
    rst = 1'b1;
    tick();
    checks++; if (game_plot !== 1'b0) $display("FAIL midop_plot: got %b want 0", game_plot); else passes++;
    checks++; if (count !== '0) $display("FAIL midop_count: got %0d want 0", count); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL midop_busy: got %b want 0", busy); else passes++;
    rst = 1'b0;
    n = 0;
    while (waitrequest && n < 100) begin
      tick();
      n++;
    end
    repeat (3) tick();
    checks++; if (acc_q.size() !== 1) $display("FAIL midop_no_reissue: got %0d accepts want 1", acc_q.size()); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL midop_idle: got busy=%b want 0", busy); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_clear();
    test_collision();
    test_midop_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
